// File: rtl/nvram_upload_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// nvram_upload_ctrl_pkg
// Shared definitions for the NVRAM upload path:
//   - upl_state_e : uploader fetch states (IDLE/ARB/RD/HOLD)
//   - NVRAM_INDEX : ioctl_index value selecting the NVRAM image, shared with
//                   the cmos_wr download decode in the core top level
//   - IOCTL_AW    : width of the data_io byte address
// -----------------------------------------------------------------------------
package nvram_upload_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,   // no fetch pending
        ST_ARB  = 2'd1,   // waiting for the shared CMOS port
        ST_RD   = 2'd2,   // address was driven last cycle, RAM data arriving
        ST_HOLD = 2'd3    // byte latched and presented on ioctl_din
    } upl_state_e;

    localparam logic [7:0] NVRAM_INDEX = 8'hFF;
    localparam int         IOCTL_AW    = 25;

endpackage

// File: rtl/nvram_upload_ctrl_addr_change_det.sv
// -----------------------------------------------------------------------------
// nvram_upload_ctrl_addr_change_det
// Remembers the address of the byte currently presented to data_io and flags
// when a new fetch is needed (selection just rose, or the requested address
// differs from the presented one). Also reports the falling edge of sel.
// Ports:
//   clk_sys, reset_n : clock, synchronous active-low reset
//   sel              : NVRAM upload selected
//   addr             : current requested address
//   load, load_addr  : update the remembered address
//   change           : new fetch required (only while sel is set)
//   sel_fall         : sel dropped this cycle
// -----------------------------------------------------------------------------
module nvram_upload_ctrl_addr_change_det
    import nvram_upload_ctrl_pkg::*;
#(
    parameter int ADDR_W = IOCTL_AW
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              sel,
    input  logic [ADDR_W-1:0] addr,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_addr,
    output logic              change,
    output logic              sel_fall
);

    logic              sel_q, sel_d;
    logic [ADDR_W-1:0] last_addr_q, last_addr_d;

    always_comb begin
        sel_d       = sel;
        last_addr_d = last_addr_q;
        if (load) begin
            last_addr_d = load_addr;
        end
    end

    // last_addr starts all-ones so no real byte address can look "already held"
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            sel_q       <= 1'b0;
            last_addr_q <= '1;
        end else begin
            sel_q       <= sel_d;
            last_addr_q <= last_addr_d;
        end
    end

    assign change   = sel && (!sel_q || (addr != last_addr_q));
    assign sel_fall = sel_q && !sel;

endmodule

// File: rtl/nvram_upload_ctrl.sv
// -----------------------------------------------------------------------------
// nvram_upload_ctrl
// Serves the CMOS/NVRAM image to data_io during an upload. Fetches the byte
// addressed by ioctl_addr from the shared single-read-port CMOS RAM, holds it
// on ioctl_din, and arbitrates the port against the game CPU with a bounded
// starvation limit.
// Optional feature: define NVRAM_DIRTY_EN to add the nv_dirty output, which
// flags CPU writes since the last complete upload.
// Ports:
//   clk_sys, reset_n        : clock, synchronous active-low reset
//   ioctl_upl/index/addr    : data_io upload request
//   ioctl_din               : byte returned to data_io
//   cpu_req/cpu_addr/cpu_we : game CPU use of the CMOS port
//   cmos_addr, cmos_q       : shared RAM port (read data one cycle later)
//   upl_busy                : fetch in flight (ARB or RD)
//   nv_dirty                : image changed since last save (NVRAM_DIRTY_EN)
// -----------------------------------------------------------------------------
module nvram_upload_ctrl
    import nvram_upload_ctrl_pkg::*;
#(
    parameter int         DEPTH        = 256,
    parameter int         AW           = $clog2(DEPTH),
    parameter logic [7:0] UPL_INDEX    = NVRAM_INDEX,
    parameter int         STARVE_LIMIT = 4
) (
    input  logic                clk_sys,
    input  logic                reset_n,
    input  logic                ioctl_upl,
    input  logic [7:0]          ioctl_index,
    input  logic [IOCTL_AW-1:0] ioctl_addr,
    output logic [7:0]          ioctl_din,
    input  logic                cpu_req,
    input  logic [AW-1:0]       cpu_addr,
    input  logic                cpu_we,
    output logic [AW-1:0]       cmos_addr,
    input  logic [7:0]          cmos_q,
    output logic                upl_busy
`ifdef NVRAM_DIRTY_EN
    ,
    output logic                nv_dirty
`endif
);

    localparam int                  CNT_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [IOCTL_AW-1:0] DEPTH_A = IOCTL_AW'(DEPTH);
    localparam logic [IOCTL_AW-1:0] LAST_A  = IOCTL_AW'(DEPTH - 1);

    upl_state_e          state_q, state_d;
    logic [7:0]          din_q, din_d;
    logic [CNT_W-1:0]    starve_cnt_q, starve_cnt_d;
    logic [IOCTL_AW-1:0] fetch_addr_q, fetch_addr_d;

    logic                sel, addr_oor, change, sel_fall;
    logic                load, drive;
    logic [IOCTL_AW-1:0] load_addr;

    assign sel      = ioctl_upl && (ioctl_index == UPL_INDEX);
    assign addr_oor = ioctl_addr >= DEPTH_A;

    nvram_upload_ctrl_addr_change_det #(
        .ADDR_W    (IOCTL_AW)
    ) u_addr_change_det (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .sel       (sel),
        .addr      (ioctl_addr),
        .load      (load),
        .load_addr (load_addr),
        .change    (change),
        .sel_fall  (sel_fall)
    );

    always_comb begin
        state_d      = state_q;
        din_d        = din_q;
        starve_cnt_d = '0;
        fetch_addr_d = fetch_addr_q;
        load         = 1'b0;
        load_addr    = ioctl_addr;
        drive        = 1'b0;
        case (state_q)
            ST_IDLE, ST_HOLD: begin
                if (!sel) begin
                    state_d = ST_IDLE;
                end else if (change) begin
                    if (addr_oor) begin
                        // Out-of-range bytes read as zero without touching RAM
                        state_d = ST_HOLD;
                        din_d   = 8'h00;
                        load    = 1'b1;
                    end else begin
                        state_d = ST_ARB;
                    end
                end
            end
            ST_ARB: begin
                // ioctl_addr is used live here, so a change while waiting
                // simply retargets the fetch and no stale byte is produced
                if (!sel) begin
                    state_d = ST_IDLE;
                end else if (addr_oor) begin
                    state_d = ST_HOLD;
                    din_d   = 8'h00;
                    load    = 1'b1;
                end else if (!cpu_req || (starve_cnt_q == CNT_W'(STARVE_LIMIT))) begin
                    drive        = 1'b1;
                    fetch_addr_d = ioctl_addr;
                    starve_cnt_d = starve_cnt_q;
                    state_d      = ST_RD;
                end else begin
                    starve_cnt_d = starve_cnt_q + CNT_W'(1);
                end
            end
            ST_RD: begin
                // Aborting here leaves the previously presented byte intact
                if (!sel) begin
                    state_d = ST_IDLE;
                end else begin
                    din_d     = cmos_q;
                    load      = 1'b1;
                    load_addr = fetch_addr_q;
                    state_d   = ST_HOLD;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            din_q        <= 8'h00;
            starve_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            din_q        <= din_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    // Only read in RD after ARB has written it, so no reset needed
    always_ff @(posedge clk_sys) begin
        fetch_addr_q <= fetch_addr_d;
    end

    assign cmos_addr = drive ? ioctl_addr[AW-1:0] : cpu_addr;
    assign ioctl_din = din_q;
    assign upl_busy  = (state_q == ST_ARB) || (state_q == ST_RD);

`ifdef NVRAM_DIRTY_EN
    logic dirty_q, dirty_d, end_seen_q, end_seen_d, dirty_set;

    always_comb begin
        dirty_set  = cpu_req && cpu_we && (int'(cpu_addr) < DEPTH);
        end_seen_d = end_seen_q;
        dirty_d    = dirty_q;
        // end_seen marks an upload that fetched the last byte of the image
        if (sel_fall) begin
            end_seen_d = 1'b0;
        end else if ((state_q == ST_RD) && sel && (fetch_addr_q == LAST_A)) begin
            end_seen_d = 1'b1;
        end
        if (sel_fall && end_seen_q) begin
            dirty_d = 1'b0;
        end
        // A write in the same cycle as the clear must not be lost
        if (dirty_set) begin
            dirty_d = 1'b1;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            dirty_q    <= 1'b0;
            end_seen_q <= 1'b0;
        end else begin
            dirty_q    <= dirty_d;
            end_seen_q <= end_seen_d;
        end
    end

    assign nv_dirty = dirty_q;
`else
    logic unused_cpu_we;
    logic unused_sel_fall;
    assign unused_cpu_we   = cpu_we;
    assign unused_sel_fall = sel_fall;
`endif

endmodule

// File: tb/tb_nvram_upload_ctrl.sv
// -----------------------------------------------------------------------------
// tb_nvram_upload_ctrl
// Directed and randomized stimulus for nvram_upload_ctrl. Expected bytes come
// from the image contents: addr < 256 returns the stored byte, otherwise 0.
// A port monitor flags any cycle where cmos_addr is not the CPU's address and
// is not a legitimate in-range uploader fetch.
// -----------------------------------------------------------------------------
module tb_nvram_upload_ctrl;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        ioctl_upl;
    logic [7:0]  ioctl_index;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_din;
    logic        cpu_req;
    logic [7:0]  cpu_addr;
    logic        cpu_we;
    logic [7:0]  cmos_addr;
    logic [7:0]  cmos_q;
    logic        upl_busy;
`ifdef NVRAM_DIRTY_EN
    logic        nv_dirty;
`endif

    logic [7:0]  mem [256];
    int          checks    = 0;
    int          errors    = 0;
    int          conflicts = 0;

    always #5 clk_sys = ~clk_sys;

    nvram_upload_ctrl dut (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .ioctl_upl   (ioctl_upl),
        .ioctl_index (ioctl_index),
        .ioctl_addr  (ioctl_addr),
        .ioctl_din   (ioctl_din),
        .cpu_req     (cpu_req),
        .cpu_addr    (cpu_addr),
        .cpu_we      (cpu_we),
        .cmos_addr   (cmos_addr),
        .cmos_q      (cmos_q),
        .upl_busy    (upl_busy)
`ifdef NVRAM_DIRTY_EN
        ,
        .nv_dirty    (nv_dirty)
`endif
    );

    // Synchronous-read CMOS RAM
    always @(posedge clk_sys) cmos_q <= mem[cmos_addr];

    // The port may leave the CPU only for an in-range uploader fetch
    always @(negedge clk_sys) begin
        if (cmos_addr !== cpu_addr) begin
            if (!(upl_busy === 1'b1 && ioctl_addr < 25'd256 && cmos_addr === ioctl_addr[7:0]))
                conflicts = conflicts + 1;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] exp_din(input logic [24:0] a);
        return (a < 25'd256) ? mem[a[7:0]] : 8'h00;
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    initial begin
        logic stale;
        reset_n     = 1'b0;
        ioctl_upl   = 1'b0;
        ioctl_index = 8'hFF;
        ioctl_addr  = '0;
        cpu_req     = 1'b0;
        cpu_addr    = 8'h42;
        cpu_we      = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h3C;
        mem[0] = 8'hA5;
        tick(3);
        chk("reset_din", ioctl_din, 8'h00);
        chk("reset_busy", upl_busy, 1'b0);
        chk("reset_cmos_addr", cmos_addr, cpu_addr);
`ifdef NVRAM_DIRTY_EN
        chk("reset_dirty", nv_dirty, 1'b0);
`endif
        reset_n = 1'b1;
        tick();

        // Wrong index must not start a fetch
        ioctl_index = 8'h01;
        ioctl_upl   = 1'b1;
        tick(4);
        chk("wrong_index_busy", upl_busy, 1'b0);
        chk("wrong_index_din", ioctl_din, 8'h00);
        ioctl_upl   = 1'b0;
        tick();
        ioctl_index = 8'hFF;

        // Uncontended first fetch
        ioctl_addr = 25'd0;
        ioctl_upl  = 1'b1;
        tick();
        chk("t1_busy_c1", upl_busy, 1'b1);
        chk("t1_din_c1", ioctl_din, 8'h00);
        tick();
        chk("t1_busy_c2", upl_busy, 1'b1);
        chk("t1_din_c2", ioctl_din, 8'h00);
        tick();
        chk("t1_busy_c3", upl_busy, 1'b0);
        chk("t1_din_c3", ioctl_din, 8'hA5);

        // Sequential sweep of the whole image
        for (int i = 0; i < 256; i++) begin
            ioctl_addr = 25'(i);
            tick(10);
            chk("sweep_din", ioctl_din, exp_din(ioctl_addr));
        end
        chk("sweep_conflicts", conflicts, 0);

        // CPU holds the port: uploader forces access on the 5th ARB cycle
        cpu_req    = 1'b1;
        cpu_addr   = 8'h11;
        ioctl_addr = 25'd5;
        tick();
        chk("starve_busy", upl_busy, 1'b1);
        chk("starve_cmos_a1", cmos_addr, 8'h11);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("starve_cmos_wait", cmos_addr, 8'h11);
        end
        tick();
        chk("starve_cmos_forced", cmos_addr, 8'h05);
        tick();
        chk("starve_din_rd", ioctl_din, 8'hC3);
        tick();
        chk("starve_din", ioctl_din, exp_din(25'd5));
        chk("starve_busy_done", upl_busy, 1'b0);
        cpu_req = 1'b0;

        // Out-of-range address
        cpu_addr   = 8'h77;
        ioctl_addr = 25'd300;
        tick();
        chk("oor_din", ioctl_din, 8'h00);
        chk("oor_busy", upl_busy, 1'b0);
        for (int k = 0; k < 4; k++) begin
            chk("oor_cmos_addr", cmos_addr, 8'h77);
            tick();
        end

        // Address change while waiting for the port
        mem[8'h40] = 8'hE1;
        mem[8'h41] = 8'h1E;
        cpu_req    = 1'b1;
        cpu_addr   = 8'h20;
        ioctl_addr = 25'h40;
        tick(2);
        ioctl_addr = 25'h41;
        tick();
        cpu_req = 1'b0;
        stale   = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (ioctl_din === 8'hE1) stale = 1'b1;
        end
        chk("arb_restart_stale", stale, 1'b0);
        chk("arb_restart_din", ioctl_din, 8'h1E);

        // sel drops mid-fetch
        ioctl_addr = 25'h42;
        tick();
        chk("abort_busy_arb", upl_busy, 1'b1);
        ioctl_upl = 1'b0;
        tick();
        chk("abort_busy", upl_busy, 1'b0);
        chk("abort_din", ioctl_din, 8'h1E);
        tick(3);
        chk("abort_din_later", ioctl_din, 8'h1E);

        // Reset during RD
        ioctl_addr = 25'h10;
        ioctl_upl  = 1'b1;
        tick(2);
        chk("rst_rd_busy", upl_busy, 1'b1);
        reset_n = 1'b0;
        tick();
        chk("rst_rd_din", ioctl_din, 8'h00);
        chk("rst_rd_busy_after", upl_busy, 1'b0);
        chk("rst_rd_cmos", cmos_addr, cpu_addr);
        reset_n   = 1'b1;
        ioctl_upl = 1'b0;
        tick(2);
        chk("rst_idle_busy", upl_busy, 1'b0);

        // Randomized addresses with random CPU traffic
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        ioctl_upl = 1'b1;
        for (int it = 0; it < 60; it++) begin
            if ($urandom_range(3) == 0) ioctl_addr = 25'($urandom_range(256, 400));
            else                        ioctl_addr = 25'($urandom_range(0, 255));
            for (int k = 0; k < 10; k++) begin
                cpu_req  = 1'($urandom_range(1));
                cpu_addr = 8'($urandom);
                tick();
            end
            chk("rand_din", ioctl_din, exp_din(ioctl_addr));
        end
        cpu_req = 1'b0;
        chk("rand_conflicts", conflicts, 0);

`ifdef NVRAM_DIRTY_EN
        ioctl_upl = 1'b0;
        reset_n   = 1'b0;
        tick();
        reset_n = 1'b1;
        chk("dirty_reset", nv_dirty, 1'b0);
        cpu_req  = 1'b1;
        cpu_we   = 1'b1;
        cpu_addr = 8'd7;
        tick();
        cpu_req = 1'b0;
        cpu_we  = 1'b0;
        chk("dirty_set", nv_dirty, 1'b1);
        ioctl_upl = 1'b1;
        for (int i = 0; i < 256; i++) begin
            ioctl_addr = 25'(i);
            tick(4);
        end
        chk("dirty_full_din", ioctl_din, exp_din(25'd255));
        chk("dirty_before_fall", nv_dirty, 1'b1);
        ioctl_upl = 1'b0;
        tick();
        chk("dirty_cleared", nv_dirty, 1'b0);
        ioctl_addr = 25'd255;
        ioctl_upl  = 1'b1;
        tick(4);
        cpu_req  = 1'b1;
        cpu_we   = 1'b1;
        cpu_addr = 8'd3;
        tick();
        cpu_req = 1'b0;
        cpu_we  = 1'b0;
        chk("dirty_set2", nv_dirty, 1'b1);
        ioctl_upl = 1'b0;
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        tick();
        cpu_req = 1'b0;
        cpu_we  = 1'b0;
        chk("dirty_set_wins", nv_dirty, 1'b1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
